// File: rtl/alien_depth_sorter.sv
// alien_depth_sorter: orders alien records by distance for the renderer.
//
// A start request snapshots obj_in, then a fixed 16*OBJ_LIMIT-cycle scan copies
// active records into a staging buffer in ascending distance order. Ties keep
// their original slot order, and inactive records are dropped. The result is
// published on obj_out/active_count in the single done cycle. The outputs are
// double-buffered, so they never show a partial sort.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   start        single-cycle sort request (ignored while busy)
//   obj_in       OBJ_LIMIT packed records, slot k at [(k+1)*REC_W-1 : k*REC_W]
//   busy         high while scanning
//   done         one-cycle pulse; obj_out/active_count valid from this cycle
//   obj_out      sorted records, same packing as obj_in, zero above active_count
//   active_count number of active records in obj_out
module alien_depth_sorter #(
    parameter int unsigned OBJ_LIMIT = 16,
    parameter int unsigned REC_W     = 35,
    parameter int unsigned R_LSB     = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [OBJ_LIMIT*REC_W-1:0]       obj_in,
    output logic                             busy,
    output logic                             done,
    output logic [OBJ_LIMIT*REC_W-1:0]       obj_out,
    output logic [$clog2(OBJ_LIMIT+1)-1:0]   active_count
);

    localparam int unsigned IW = (OBJ_LIMIT > 1) ? $clog2(OBJ_LIMIT) : 1;
    localparam int unsigned CW = $clog2(OBJ_LIMIT + 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                   state_q, state_d;
    logic [REC_W-1:0]         snap_q  [OBJ_LIMIT];
    logic [REC_W-1:0]         snap_d  [OBJ_LIMIT];
    logic [REC_W-1:0]         stage_q [OBJ_LIMIT];
    logic [REC_W-1:0]         stage_d [OBJ_LIMIT];
    logic [3:0]               key_q, key_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [CW-1:0]            wptr_q, wptr_d;
    logic [OBJ_LIMIT*REC_W-1:0] out_q, out_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    logic [REC_W-1:0]         cur_rec;
    logic                     hit;
    logic                     idx_last;
    logic                     scan_last;

    assign cur_rec   = snap_q[idx_q];
    assign hit       = cur_rec[0] && (cur_rec[R_LSB +: 4] == key_q);
    assign idx_last  = (idx_q == IW'(OBJ_LIMIT - 1));
    assign scan_last = idx_last && (key_q == 4'hF);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        stage_d = stage_q;
        key_d   = key_q;
        idx_d   = idx_q;
        wptr_d  = wptr_q;
        out_d   = out_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d = StScan;
                    for (int k = 0; k < OBJ_LIMIT; k++) begin
                        snap_d[k]  = obj_in[k*REC_W +: REC_W];
                        // Staging starts clean so unused slots read back as zero.
                        stage_d[k] = '0;
                    end
                    key_d  = '0;
                    idx_d  = '0;
                    wptr_d = '0;
                end
            end
            StScan: begin
                if (hit && (wptr_q < CW'(OBJ_LIMIT))) begin
                    stage_d[wptr_q[IW-1:0]] = cur_rec;
                    wptr_d                  = wptr_q + CW'(1);
                end
                if (idx_last) begin
                    idx_d = '0;
                    key_d = key_q + 4'd1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
                if (scan_last) begin
                    // Publish including this final cycle's write.
                    state_d = StDone;
                    for (int k = 0; k < OBJ_LIMIT; k++) begin
                        out_d[k*REC_W +: REC_W] = stage_d[k];
                    end
                    cnt_d = wptr_d;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            snap_q  <= '{default: '0};
            stage_q <= '{default: '0};
            key_q   <= '0;
            idx_q   <= '0;
            wptr_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            stage_q <= stage_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            wptr_q  <= wptr_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy         = (state_q == StScan);
    assign done         = (state_q == StDone);
    assign obj_out      = out_q;
    assign active_count = cnt_q;

endmodule

// File: tb/tb_alien_depth_sorter.sv
// Self-checking bench for alien_depth_sorter: table-driven sorts, checked through
// a scoreboard of expected results and done cycles, plus multi-cycle corner cases.
module tb_alien_depth_sorter;

    localparam int N  = 16;
    localparam int W  = 35;
    localparam int OW = N * W;
    localparam int LAT = 16 * N + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [OW-1:0] obj_in;
    logic          busy;
    logic          done;
    logic [OW-1:0] obj_out;
    logic [4:0]    active_count;

    alien_depth_sorter #(.OBJ_LIMIT(N), .REC_W(W), .R_LSB(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .obj_in       (obj_in),
        .busy         (busy),
        .done         (done),
        .obj_out      (obj_out),
        .active_count (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] exp_out;
        int            exp_cnt;
        int            exp_cyc;
    } sb_t;

    typedef struct {
        string         name;
        logic [OW-1:0] in;
        logic [OW-1:0] exp_out;
        int            exp_cnt;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[4];
    int   checks     = 0;
    int   failures   = 0;
    int   done_seen  = 0;

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mkrec(input bit act, input int r, input int tag);
        logic [W-1:0] v;
        v       = '0;
        v[0]    = act;
        v[4:1]  = 4'(tag);
        v[8:5]  = 4'(r);
        v[34:9] = 26'(tag * 7 + 3);
        return v;
    endfunction

    // Reference: gather active records in slot order, then stable insertion sort by r.
    task automatic model(input logic [OW-1:0] in, output logic [OW-1:0] out, output int cnt);
        logic [W-1:0] lst [N];
        logic [W-1:0] t;
        int           j;
        cnt = 0;
        out = '0;
        for (int k = 0; k < N; k++) begin
            t = in[k*W +: W];
            if (t[0]) begin
                lst[cnt] = t;
                cnt++;
            end
        end
        for (int i = 1; i < cnt; i++) begin
            t = lst[i];
            j = i - 1;
            while (j >= 0 && lst[j][8:5] > t[8:5]) begin
                lst[j+1] = lst[j];
                j--;
            end
            lst[j+1] = t;
        end
        for (int k = 0; k < cnt; k++) out[k*W +: W] = lst[k];
    endtask

    // Scoreboard consumer: every done must match the oldest outstanding request.
    always @(negedge clk) begin
        sb_t e;
        if (rst && done) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done at cycle %0d want no done", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", OW'(cyc), OW'(e.exp_cyc));
                chk("obj_out", obj_out, e.exp_out);
                chk("active_count", OW'(active_count), OW'(e.exp_cnt));
            end
        end
    end

    task automatic pulse_start(input logic [OW-1:0] in, input logic [OW-1:0] exp, input int cnt);
        @(negedge clk);
        obj_in = in;
        start  = 1'b1;
        sb.push_back('{exp_out: exp, exp_cnt: cnt, exp_cyc: cyc + LAT});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 2 * LAT && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d pending want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    logic [OW-1:0] mixed_in, mixed_exp, full_in, v;
    int            d0, cnt;

    initial begin
        // Stimulus tables.
        mixed_in = '0;
        for (int k = 0; k < N; k++) mixed_in[k*W +: W] = mkrec(1'b0, k, k + 40);
        mixed_in[0*W +: W] = mkrec(1'b1, 9, 0);
        mixed_in[1*W +: W] = mkrec(1'b1, 2, 1);
        mixed_in[2*W +: W] = mkrec(1'b1, 2, 2);
        mixed_in[3*W +: W] = mkrec(1'b1, 15, 3);
        mixed_exp = '0;
        mixed_exp[0*W +: W] = mkrec(1'b1, 2, 1);
        mixed_exp[1*W +: W] = mkrec(1'b1, 2, 2);
        mixed_exp[2*W +: W] = mkrec(1'b1, 9, 0);
        mixed_exp[3*W +: W] = mkrec(1'b1, 15, 3);
        vecs[0] = '{name: "mixed", in: mixed_in, exp_out: mixed_exp, exp_cnt: 4};

        v = '0;
        for (int k = 0; k < N; k++) v[k*W +: W] = mkrec(1'b0, 15 - k, k + 9);
        vecs[1] = '{name: "empty", in: v, exp_out: '0, exp_cnt: 0};

        full_in = '0;
        for (int k = 0; k < N; k++) full_in[k*W +: W] = mkrec(1'b1, 0, k + 100);
        vecs[2] = '{name: "full_tie", in: full_in, exp_out: full_in, exp_cnt: 16};

        v = '0;
        for (int k = 0; k < N; k++)
            v[k*W +: W] = mkrec(1'($urandom_range(0, 1)), $urandom_range(0, 15),
                                $urandom_range(0, 1000));
        vecs[3].name = "random";
        vecs[3].in   = v;
        model(v, vecs[3].exp_out, vecs[3].exp_cnt);

        // Reset held with start asserted.
        rst    = 1'b0;
        start  = 1'b1;
        obj_in = full_in;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", OW'(busy), '0);
            chk("rst_done", OW'(done), '0);
            chk("rst_obj_out", obj_out, '0);
            chk("rst_count", OW'(active_count), '0);
        end
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;

        // Table-driven sorts.
        for (int i = 0; i < 4; i++) begin
            pulse_start(vecs[i].in, vecs[i].exp_out, vecs[i].exp_cnt);
            chk({vecs[i].name, "_busy"}, OW'(busy), OW'(1));
            wait_drain(vecs[i].name);
            @(negedge clk);
            chk({vecs[i].name, "_idle_busy"}, OW'(busy), '0);
            chk({vecs[i].name, "_hold"}, obj_out, vecs[i].exp_out);
        end

        // Start during SCAN with changed obj_in is ignored.
        d0 = done_seen;
        pulse_start(mixed_in, mixed_exp, 4);
        repeat (8) @(negedge clk);
        obj_in = full_in;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("interfere");
        repeat (300) @(negedge clk);
        chk("interfere_one_done", OW'(done_seen - d0), OW'(1));

        // Back-to-back: second start in the DONE cycle.
        pulse_start(full_in, full_in, 16);
        for (int i = 0; i < 2 * LAT && !done; i++) @(negedge clk);
        obj_in = mixed_in;
        start  = 1'b1;
        sb.push_back('{exp_out: mixed_exp, exp_cnt: 4, exp_cyc: cyc + LAT});
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("b2b_busy", OW'(busy), OW'(1));
        chk("b2b_hold_out", obj_out, full_in);
        chk("b2b_hold_cnt", OW'(active_count), OW'(16));
        wait_drain("b2b");

        // Abort mid-scan.
        pulse_start(full_in, full_in, 16);
        repeat (99) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        d0 = done_seen;
        repeat (2) @(negedge clk);
        chk("abort_busy", OW'(busy), '0);
        chk("abort_out", obj_out, '0);
        chk("abort_cnt", OW'(active_count), '0);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        chk("abort_no_done", OW'(done_seen - d0), '0);
        model(mixed_in, v, cnt);
        pulse_start(mixed_in, v, cnt);
        wait_drain("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alien_depth_sorter.md
ALIEN_DEPTH_SORTER -- requirements
Module: alien_depth_sorter

Interface
REQ-001 Parameter OBJ_LIMIT, default 16: number of alien record slots.
REQ-002 Parameter REC_W, default 35: width of one packed alien record (AlienData layout).
REQ-003 Parameter R_LSB, default 5: bit position of the 4-bit distance field r within a record (bits R_LSB+3:R_LSB); bit 0 is the active flag.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 start  input  1  single-cycle request to sort obj_in.
REQ-007 obj_in  input  OBJ_LIMIT*REC_W  unsorted records; slot k occupies bits (k+1)*REC_W-1 : k*REC_W.
REQ-008 busy  output  1  sort in progress.
REQ-009 done  output  1  single-cycle pulse; obj_out/active_count updated this cycle.
REQ-010 obj_out  output  OBJ_LIMIT*REC_W  sorted records, same slot packing as obj_in; feeds the frame-data field of the output datagram.
REQ-011 active_count  output  $clog2(OBJ_LIMIT+1)  number of active records in obj_out.

Function
REQ-012 The block SHALL implement states IDLE, SCAN, DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; start in SCAN SHALL be ignored with no effect.
REQ-014 On acceptance the block SHALL copy obj_in into an internal snapshot, clear the write pointer, key and index counters to 0, and enter SCAN; later obj_in changes SHALL NOT affect the result.
REQ-015 SCAN SHALL visit one (key, index) pair per cycle: index 0..OBJ_LIMIT-1 inner, key 0..15 outer, 16*OBJ_LIMIT cycles total.
REQ-016 When snapshot[index] is active and its r equals key, the record SHALL be written to staging slot write_ptr and write_ptr incremented.
REQ-017 Resulting order: active records by ascending r (nearest first); ties by ascending original index; inactive records SHALL be dropped.
REQ-018 Staging slots at or above the final write_ptr SHALL be all-zero.
REQ-019 After the last SCAN cycle the block SHALL enter DONE for one cycle, assert done, and present staging contents on obj_out and write_ptr on active_count in that same cycle.
REQ-020 DONE SHALL return to IDLE the following cycle unless start is accepted, in which case it enters SCAN.
REQ-021 Latency: done SHALL be high exactly 16*OBJ_LIMIT+1 cycles after the cycle in which start was sampled; it is independent of data.
REQ-022 busy SHALL be 1 exactly in SCAN and 0 in IDLE and DONE.
REQ-023 obj_out and active_count SHALL hold their previous values from acceptance until the done cycle (double-buffered); the downstream renderer never sees partial results.
REQ-024 write_ptr SHALL not exceed OBJ_LIMIT; active_count = OBJ_LIMIT when all slots are active.

Reset
REQ-025 While rst=0 at a clk edge: state IDLE, busy=0, done=0, obj_out=0, active_count=0, snapshot, staging and counters cleared.
REQ-026 Reset mid-SCAN SHALL abort the sort with no done pulse; the next start after release SHALL behave as from power-up.

Verification
REQ-027 Reset: hold rst=0 for 3 cycles with start=1 -> busy=0, done=0, obj_out=0, active_count=0 throughout.
REQ-028 Mixed: slots 0..3 active with r=9,2,2,15, others inactive; pulse start -> done at +257 cycles; obj_out slots 0..3 = original 1,2,0,3; slots 4..15 zero; active_count=4.
REQ-029 Empty: all slots inactive -> done at +257 cycles; obj_out all zero; active_count=0.
REQ-030 Full tie: all 16 active, r=0 -> obj_out equals obj_in; active_count=16.
REQ-031 Interference: start accepted, then at +10 change obj_in and pulse start -> exactly one done at +257, result matches the original snapshot; back-to-back start in the DONE cycle -> second done 257 cycles later.
REQ-032 Abort: rst=0 at cycle 100 of SCAN -> no done pulse, outputs zero; new start after release -> correct result at +257 cycles.
